// File: rtl/sparkdream_pkg.sv
// Shared constants and types for the SParkDream debug dataframe capture path.
// Holds the frame/word geometry of the 128 x 448-bit dataframe RAM and the
// capture controller state encoding.
package sparkdream_pkg;

    localparam int unsigned FRAME_W    = 448;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned N_WORDS    = 14;
    localparam int unsigned DEPTH_LOG2 = 7;
    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } dfcap_state_t;

endpackage

// File: rtl/dfcap_word_mux.sv
// Combinational 448 -> 32 word slicer for host readback of a stored dataframe.
// Ports:
//   frame_i    stored dataframe (RAM read data)
//   sel_i      word index within the frame, valid range 0..N_WORDS-1
//   word_o     selected 32-bit word, zero when sel_i is out of range
//   sel_err_o  high when sel_i is out of range
module dfcap_word_mux
    import sparkdream_pkg::*;
(
    input  logic [FRAME_W-1:0] frame_i,
    input  logic [3:0]         sel_i,
    output logic [WORD_W-1:0]  word_o,
    output logic               sel_err_o
);

    always_comb begin
        word_o    = '0;
        sel_err_o = (sel_i > 4'(N_WORDS - 1));
        // Explicit compare per word keeps the part-select in range for sel 14/15.
        for (int i = 0; i < int'(N_WORDS); i++) begin
            if (sel_i == 4'(i)) begin
                word_o = frame_i[i*WORD_W +: WORD_W];
            end
        end
    end

endmodule

// File: rtl/dataframe_capture_ctrl.sv
// Capture controller for the 128-deep, 448-bit debug dataframe RAM.
// Arms/stops capture of incoming dataframes, sequences the RAM write pointer,
// shares the RAM's single address port between capture and host readback,
// and slices stored frames into 32-bit words for the register interface.
//
// Build option: define DFCAP_WRAP_EN for ring mode (capture wraps and only
// stop ends it; readback addresses are logical, oldest frame first).
// Default build is single-shot: capture ends after 128 stored frames.
//
// Ports:
//   CLKA, rst          clock, asynchronous active-low reset
//   frame_in/_valid    dataframe stream from the deserializer
//   arm, stop          capture control pulses
//   rd_req/addr/sel    host read request (frame index, word index)
//   rd_data/valid/err  registered read response, one cycle after rd_req
//   busy, done         registered state flags
//   capture_count      frames stored, saturating at 128
//   ram_*              external RAM port (asynchronous read of ram_addra)
module dataframe_capture_ctrl
    import sparkdream_pkg::*;
(
    input  logic                  CLKA,
    input  logic                  rst,
    input  logic [FRAME_W-1:0]    frame_in,
    input  logic                  frame_valid,
    input  logic                  arm,
    input  logic                  stop,
    input  logic                  rd_req,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    input  logic [3:0]            rd_word_sel,
    output logic [WORD_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  rd_err,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            capture_count,
    output logic [DEPTH_LOG2-1:0] ram_addra,
    output logic [FRAME_W-1:0]    ram_dina,
    output logic                  ram_wea,
    input  logic [FRAME_W-1:0]    ram_douta
);

    localparam logic [7:0] CountMax = 8'(DEPTH);

    dfcap_state_t          state_q, state_d;
    logic [DEPTH_LOG2-1:0] write_head_q, write_head_d;
    logic [7:0]            capture_count_q, capture_count_d;
    logic [WORD_W-1:0]     rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_err_q, rd_err_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
`ifdef DFCAP_WRAP_EN
    logic                  wrapped_q, wrapped_d;
`endif

    logic                  capturing;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] rd_phys_addr;
    logic [WORD_W-1:0]     sel_word;
    logic                  sel_err;

    assign capturing = (state_q == CAPTURE);
    assign wr_en     = capturing && frame_valid;

`ifdef DFCAP_WRAP_EN
    // Once wrapped, the oldest frame sits at write_head; rebase logical index.
    assign rd_phys_addr = wrapped_q ? (write_head_q + rd_addr) : rd_addr;
`else
    assign rd_phys_addr = rd_addr;
`endif

    // Capture owns the address port for the whole CAPTURE state.
    assign ram_addra = capturing ? write_head_q : rd_phys_addr;
    assign ram_dina  = frame_in;
    assign ram_wea   = wr_en;

    dfcap_word_mux u_word_mux (
        .frame_i   (ram_douta),
        .sel_i     (rd_word_sel),
        .word_o    (sel_word),
        .sel_err_o (sel_err)
    );

    always_comb begin
        state_d         = state_q;
        write_head_d    = write_head_q;
        capture_count_d = capture_count_q;
`ifdef DFCAP_WRAP_EN
        wrapped_d       = wrapped_q;
`endif
        rd_data_d       = rd_data_q;
        rd_valid_d      = 1'b0;
        rd_err_d        = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                // arm wins over a coincident stop, which is meaningless here.
                if (arm) begin
                    state_d         = CAPTURE;
                    write_head_d    = '0;
                    capture_count_d = '0;
`ifdef DFCAP_WRAP_EN
                    wrapped_d       = 1'b0;
`endif
                end
            end
            CAPTURE: begin
                if (wr_en) begin
                    write_head_d = write_head_q + 1'b1;
                    if (capture_count_q != CountMax) begin
                        capture_count_d = capture_count_q + 8'd1;
                    end
`ifdef DFCAP_WRAP_EN
                    if (write_head_q == '1) begin
                        wrapped_d = 1'b1;
                    end
`else
                    if (capture_count_q == CountMax - 8'd1) begin
                        state_d = DONE;
                    end
`endif
                end
                // A frame coincident with stop has already been written above.
                if (stop) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rd_req) begin
            if (capturing || sel_err) begin
                rd_err_d = 1'b1;
            end else begin
                rd_valid_d = 1'b1;
                rd_data_d  = sel_word;
            end
        end

        busy_d = (state_d == CAPTURE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge CLKA or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            write_head_q    <= '0;
            capture_count_q <= '0;
`ifdef DFCAP_WRAP_EN
            wrapped_q       <= 1'b0;
`endif
            rd_data_q       <= '0;
            rd_valid_q      <= 1'b0;
            rd_err_q        <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            write_head_q    <= write_head_d;
            capture_count_q <= capture_count_d;
`ifdef DFCAP_WRAP_EN
            wrapped_q       <= wrapped_d;
`endif
            rd_data_q       <= rd_data_d;
            rd_valid_q      <= rd_valid_d;
            rd_err_q        <= rd_err_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign rd_err        = rd_err_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign capture_count = capture_count_q;

endmodule

// File: doc/dataframe_capture_ctrl.md
# dataframe_capture_ctrl

Controller for the 128-deep, 448-bit debug dataframe RAM in the SParkDream pixel-parser path. The block arms and stops capture of incoming 28×16-bit dataframes and sequences the RAM write pointer. It owns the RAM's single address port, sharing it between capture writes and host readback. It also slices each stored 448-bit frame into 32-bit words for the Caribou register interface.

## Interface
- DEPTH_LOG2, 7, log2 of RAM depth (128 frames)
- FRAME_W, 448, dataframe width
- WORD_W, 32, host readback word width
- CLKA  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- frame_in  in  448  dataframe from deserializer
- frame_valid  in  1  frame_in valid this cycle
- arm  in  1  pulse: clear pointers, start capture
- stop  in  1  pulse: end capture
- rd_req  in  1  host read request, one cycle
- rd_addr  in  7  frame index to read
- rd_word_sel  in  4  32-bit word within frame, 0..13
- rd_data  out  32  read word
- rd_valid  out  1  rd_data valid pulse
- rd_err  out  1  rejected read pulse
- busy  out  1  state == CAPTURE
- done  out  1  state == DONE
- capture_count  out  8  frames stored, saturates at 128
- ram_addra  out  7  RAM address
- ram_dina  out  448  RAM write data (= frame_in)
- ram_wea  out  1  RAM write enable
- ram_douta  in  448  RAM read data, asynchronous read of ram_addra

## Operation
- States: IDLE, CAPTURE, DONE. Reset enters IDLE.
- IDLE or DONE, arm=1 -> CAPTURE.
  - write_head=0, capture_count=0, wrapped=0.
- CAPTURE, frame_valid=1:
  - ram_wea=1, ram_addra=write_head.
  - write_head++ (mod 128), capture_count++ (saturating).
- CAPTURE, single-shot: the 128th write (capture_count 127->128) -> DONE. Later frames are ignored.
- CAPTURE, stop=1 -> DONE.
  - stop and frame_valid in the same cycle: the frame is written, then DONE.
- arm during CAPTURE: ignored. stop outside CAPTURE: ignored. arm+stop in IDLE: arm wins.
- Readback accepted only in IDLE/DONE:
  - ram_addra = physical address.
  - rd_data = ram_douta[rd_word_sel*32 +: 32].
- Rejected reads: rd_req in CAPTURE, or rd_word_sel > 13 -> rd_err pulse, rd_valid=0, rd_data unchanged.
- Address mux: CAPTURE -> write_head, else read address. Capture always has priority.

## Timing
- Reset values: rd_data=0, rd_valid=0, rd_err=0, busy=0, done=0, capture_count=0, write_head=0, wrapped=0.
- ram_wea, ram_addra, ram_dina: combinational from current state and inputs.
- Write occurs on the same CLKA edge that samples frame_valid.
- Read latency 1: rd_req at cycle N -> rd_valid/rd_data registered at N+1.
- Back-to-back rd_req every cycle is supported.
- busy/done are registered and reflect the state after each edge.
- Reset mid-capture: immediate return to IDLE, counters cleared. RAM contents retained but not valid.

## Configuration
- DFCAP_WRAP_EN defined (ring mode):
  - Capture never self-terminates; write_head wraps 127->0.
  - wrapped is set on the first wrap; capture_count saturates at 128.
  - Only stop ends capture.
  - Readback rd_addr is logical, oldest first: physical = wrapped ? (write_head + rd_addr) mod 128 : rd_addr.
- DFCAP_WRAP_EN undefined: single-shot as above; physical address = rd_addr; no wrapped register.

## Structure
- sparkdream_pkg holds:
  - FRAME_W=448, WORD_W=32, N_WORDS=14, DEPTH_LOG2=7.
  - dfcap_state_t enum {IDLE, CAPTURE, DONE}.
- Sub-module dfcap_word_mux: combinational 448->32 slice with range check (sel>13 flag).
- The RAM itself stays external.

## Test plan
- Single-shot fill:
  - arm, then 130 frames; frame k = {28{16'(k)}}.
  - Required: exactly 128 ram_wea pulses, addr 0..127; done=1; capture_count=128.
  - Read addr 5, sel 3 -> rd_data=0x00050005 one cycle later.
- Early stop: arm, 10 frames, then stop coincident with the 11th frame -> capture_count=11, DONE, last write at addr 10.
- Read during capture: rd_req while busy=1 -> rd_err=1, rd_valid=0, ram_addra stays at write_head.
- Bad word select: rd_word_sel=14 in DONE -> rd_err=1, rd_data unchanged.
- Reset mid-capture: rst low after 40 frames -> all outputs at reset values. New arm restarts writes at addr 0.
- DFCAP_WRAP_EN: 200 frames, then stop -> capture_count=128, wrapped=1. Logical addr 0 -> physical 72 returns frame 72.
